// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int STAT_W = 16;

  // Width of an index into NUM_REQ requesters (never narrower than one bit).
  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit searching last+1, last+2, ... (mod NUM_REQ).
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int OW      = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      last,
  output logic [OW-1:0]      pick,
  output logic               valid
);

  logic [NUM_REQ-1:0] rot;
  int                 start;
  int                 idx;
  int                 src;
  int                 sum;

  always_comb begin
    start = int'(last) + 1;
    if (start >= NUM_REQ) start = 0;
    // rotate so that bit 0 of rot is the highest-priority requester
    rot = '0;
    src = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      src = start + k;
      if (src >= NUM_REQ) src = src - NUM_REQ;
      rot[k] = req[src];
    end
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) idx = k;
    end
    sum = idx + start;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    pick  = OW'(sum);
    valid = |req;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of the async FIFO write port.
// Optional per-requester write/stall counters under FIFO_WRITE_ARBITER_STATS_EN.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 4,
  localparam int OW        = owner_w(NUM_REQ)
) (
  input  logic                     write_clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     full,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     write_en,
  output logic [WIDTH-1:0]         data_in,
  output logic [OW-1:0]            owner,
  output logic                     busy
`ifdef FIFO_WRITE_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] write_count,
  output logic [STAT_W-1:0]         stall_count
`endif
);

  arb_state_t    state;
  logic [OW-1:0] last;
  logic [7:0]    burst_cnt;
  logic [OW-1:0] pick;
  logic          pick_vld;
  logic          own_req;
  logic          accept;
  logic          burst_end;

  fifo_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .last  (last),
    .pick  (pick),
    .valid (pick_vld)
  );

  // Zero-latency write path; reset masks it so an aborted burst writes nothing.
  assign own_req   = req[owner];
  assign accept    = (state == ARB_BURST) & own_req & ~full & ~reset;
  assign write_en  = accept;
  assign grant     = accept ? (NUM_REQ'(1) << owner) : '0;
  assign data_in   = accept ? req_data[owner*WIDTH +: WIDTH] : '0;
  assign busy      = (state == ARB_BURST);
  assign burst_end = accept & (burst_cnt == 8'(MAX_BURST - 1));

  always_ff @(posedge write_clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      last      <= OW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            owner     <= pick;
            burst_cnt <= '0;
            state     <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          // A dropped request ends the burst even while full is high.
          if (!own_req || burst_end) begin
            last  <= owner;
            state <= ARB_IDLE;
          end
          if (accept) burst_cnt <= burst_cnt + 8'd1;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_wcnt
    always_ff @(posedge write_clk) begin
      if (reset)         write_count[i*STAT_W +: STAT_W] <= '0;
      else if (grant[i]) write_count[i*STAT_W +: STAT_W] <= write_count[i*STAT_W +: STAT_W] + 1'b1;
    end
  end

  always_ff @(posedge write_clk) begin
    if (reset)                    stall_count <= '0;
    else if (busy & own_req & full) stall_count <= stall_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter against a queue-level arbitration model.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MB = 4;

  logic           write_clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           full;
  logic [N-1:0]   grant;
  logic           write_en;
  logic [W-1:0]   data_in;
  logic [1:0]     owner;
  logic           busy;
`ifdef FIFO_WRITE_ARBITER_STATS_EN
  logic [N*16-1:0] write_count;
  logic [15:0]     stall_count;
`endif

  fifo_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .write_clk (write_clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .full      (full),
    .grant     (grant),
    .write_en  (write_en),
    .data_in   (data_in),
    .owner     (owner),
    .busy      (busy)
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    ,
    .write_count (write_count),
    .stall_count (stall_count)
`endif
  );

  always #5 write_clk = ~write_clk;

  int vectors = 0;
  int miscompares = 0;

  // Requesters: pend[i] words still to write, dat[i] the word on offer.
  int         pend[N];
  logic [W-1:0] dat[N];
  logic       full_v, rst_v;

  // Model: who owns the port, whom to search after, writes so far in this grant.
  bit m_busy;
  int m_owner, m_last, m_cnt;
  int m_wc[N];
  int m_sc;

  // Last observed DUT values for the hand-computed checks.
  logic         d_we, d_busy;
  logic [N-1:0] d_grant;
  logic [1:0]   d_owner;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    bit exp_acc;
    for (int i = 0; i < N; i++) begin
      req[i] = (pend[i] > 0);
      req_data[i*W +: W] = dat[i];
    end
    full  = full_v;
    reset = rst_v;
    @(negedge write_clk);
    exp_acc = !rst_v && m_busy && req[m_owner] && !full_v;
    chk("write_en", write_en, exp_acc);
    chk("grant", grant, exp_acc ? (64'd1 << m_owner) : 64'd0);
    chk("data_in", data_in, exp_acc ? dat[m_owner] : '0);
    chk("busy", busy, m_busy);
    chk("owner", owner, m_owner);
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) chk("write_count", write_count[i*16 +: 16], m_wc[i] & 16'hFFFF);
    chk("stall_count", stall_count, m_sc & 16'hFFFF);
`endif
    d_we = write_en; d_busy = busy; d_grant = grant; d_owner = owner;
    // statistics
    if (rst_v) begin
      for (int i = 0; i < N; i++) m_wc[i] = 0;
      m_sc = 0;
    end else begin
      if (exp_acc) m_wc[m_owner]++;
      if (m_busy && req[m_owner] && full_v) m_sc++;
    end
    // requester consumes the word it was granted
    if (exp_acc) begin
      pend[m_owner]--;
      dat[m_owner] = $urandom;
    end
    // arbitration rules
    if (rst_v) begin
      m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
    end else if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        if (!m_busy && req[(m_last + k) % N]) begin
          m_busy = 1; m_owner = (m_last + k) % N; m_cnt = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end else if (!full_v) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_busy = 0; m_last = m_owner;
      end
    end
    @(posedge write_clk);
    #1;
  endtask

  task automatic reset_step();
    for (int i = 0; i < N; i++) pend[i] = 0;
    full_v = 0;
    rst_v  = 1;
    step();
    rst_v  = 0;
  endtask

  int exp_single[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  int oq[$];
  int nw, nidle;

  initial begin
    m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0; m_sc = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 100; dat[i] = $urandom; m_wc[i] = 0;
    end
    full_v = 0;
    rst_v  = 1;

    // reset held with all requesting
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_we", d_we, 0);
      chk("rst_grant", d_grant, 0);
      chk("rst_busy", d_busy, 0);
      chk("rst_owner", d_owner, 0);
    end
    rst_v = 0;
    step();
    chk("rst_arb_idle", d_busy, 0);
    step();
    chk("rst_first_grant", d_grant, 4'b0001);

    // single requester, six words
    reset_step();
    pend[2] = 6;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("single_we", d_we, exp_single[c]);
      if (d_we) chk("single_grant", d_grant, 4'b0100);
    end

    // all requesting, four words each
    reset_step();
    for (int i = 0; i < N; i++) pend[i] = 4;
    nidle = 0;
    for (int c = 0; c < 22; c++) begin
      step();
      if (d_we) oq.push_back(int'(d_owner));
      else if (c < 20) nidle++;
    end
    chk("all_nwrites", oq.size(), 16);
    for (int k = 0; k < oq.size() && k < 16; k++) chk("all_owner_seq", oq[k], k / 4);
    chk("all_idle_gaps", nidle, 4);
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) chk("all_wcount", write_count[i*16 +: 16], 4);
`endif

    // full stall on requester 1 after its second write
    reset_step();
    pend[1] = 6;
    step();
    step();
    step();
    chk("stall_pre_writes", d_grant, 4'b0010);
    full_v = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_we", d_we, 0);
      chk("stall_grant", d_grant, 0);
      chk("stall_owner", d_owner, 1);
      chk("stall_busy", d_busy, 1);
    end
    full_v = 0;
    nw = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (d_we) nw++;
    end
    chk("stall_post_writes", nw, 2);
    step();
    chk("stall_burst_end", d_busy, 0);
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    chk("stall_count", stall_count, 3);
`endif
    for (int c = 0; c < 4; c++) step();

    // early drop by requester 3, then reset in the middle of a burst
    reset_step();
    pend[3] = 1;
    step();
    step();
    chk("drop_write", d_grant, 4'b1000);
    step();
    chk("drop_busy", d_busy, 1);
    chk("drop_we", d_we, 0);
    pend[0] = 1;
    pend[2] = 5;
    step();
    chk("drop_idle", d_busy, 0);
    step();
    chk("drop_next_pick", d_grant, 4'b0001);
    step();
    step();
    step();
    chk("mid_burst_owner", d_grant, 4'b0100);
    rst_v = 1;
    step();
    chk("mid_rst_we", d_we, 0);
    rst_v = 0;
    step();
    chk("post_rst_busy", d_busy, 0);
    chk("post_rst_owner", d_owner, 0);
    chk("post_rst_grant", d_grant, 0);

    // randomized traffic with stalls and occasional resets
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (pend[i] == 0 && $urandom_range(0, 3) == 0) pend[i] = $urandom_range(1, 7);
      full_v = ($urandom_range(0, 3) == 0);
      rst_v  = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
